// File: rtl/ecr_allocator.sv
`default_nettype none
// ============================================================================
// Module   : ecr_allocator
// Purpose  : Round-robin allocator for execution condition registers with a
//            FREE/ALLOC/DRAIN lifecycle per entry.
// Revision : 1.0
// ============================================================================
module ecr_allocator #(
    parameter int         NUM_ECRS   = 8,
    parameter int         ID_WIDTH   = 4,
    parameter logic [1:0] IDLE_STATE = 2'b00,
    localparam int        IDX_WIDTH  = $clog2(NUM_ECRS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               alloc_req,
    input  logic [ID_WIDTH-1:0]                alloc_issue_id,
    output logic                               alloc_gnt,
    output logic [IDX_WIDTH-1:0]               alloc_idx,
    input  logic                               free_req,
    input  logic [IDX_WIDTH-1:0]               free_idx,
    input  logic                               flush,
    input  logic [NUM_ECRS-1:0][1:0]           monitor_states,
    output logic [NUM_ECRS-1:0]                busy_mask,
    output logic [NUM_ECRS-1:0][ID_WIDTH-1:0]  owner_id,
    output logic [IDX_WIDTH:0]                 free_count,
    output logic                               err_bad_free
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_DRAIN = 2'd2
    } ecr_state_e;

    localparam logic [IDX_WIDTH:0]   c_num  = (IDX_WIDTH+1)'(NUM_ECRS);
    localparam logic [IDX_WIDTH-1:0] c_last = IDX_WIDTH'(NUM_ECRS - 1);

    ecr_state_e                        r_state      [NUM_ECRS];
    ecr_state_e                        w_state_next [NUM_ECRS];
    logic [NUM_ECRS-1:0][ID_WIDTH-1:0] r_owner;
    logic [NUM_ECRS-1:0]               r_busy;
    logic [IDX_WIDTH-1:0]              r_rr_ptr;
    logic [IDX_WIDTH-1:0]              w_rr_ptr_next;
    logic [IDX_WIDTH:0]                r_free_count;
    logic [IDX_WIDTH:0]                w_free_count_next;
    logic                              r_err;

    logic [IDX_WIDTH-1:0]              w_pick;
    logic                              w_found;
    logic [IDX_WIDTH:0]                w_sum;
    logic                              w_gnt;
    logic [NUM_ECRS-1:0]               w_free_hit;
    logic [NUM_ECRS-1:0]               w_is_alloc;
    logic                              w_free_legal;

    // Search for the first FREE entry starting at rr_ptr, wrapping at NUM_ECRS.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_ECRS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_WIDTH+1)'(k);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            if (!w_found && (r_state[w_sum[IDX_WIDTH-1:0]] == ST_FREE)) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_WIDTH-1:0];
            end
        end
    end

    assign w_gnt     = alloc_req & ~flush & ~rst & (r_free_count != '0);
    assign alloc_gnt = w_gnt;
    assign alloc_idx = w_gnt ? w_pick : '0;

    // Out-of-range indices never match any entry, so they fall out as illegal.
    always_comb begin
        w_free_hit = '0;
        w_is_alloc = '0;
        for (int i = 0; i < NUM_ECRS; i++) begin
            w_free_hit[i] = free_req && (free_idx == IDX_WIDTH'(i));
            w_is_alloc[i] = (r_state[i] == ST_ALLOC);
        end
        w_free_legal = |(w_free_hit & w_is_alloc);
    end

    always_comb begin
        w_free_count_next = '0;
        for (int i = 0; i < NUM_ECRS; i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                ST_FREE: begin
                    if (w_gnt && (w_pick == IDX_WIDTH'(i))) begin
                        w_state_next[i] = ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (flush || w_free_hit[i]) begin
                        w_state_next[i] = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (monitor_states[i] == IDLE_STATE) begin
                        w_state_next[i] = ST_FREE;
                    end
                end
                default: w_state_next[i] = ST_FREE;
            endcase
            if (w_state_next[i] == ST_FREE) begin
                w_free_count_next = w_free_count_next + 1'b1;
            end
        end
        w_rr_ptr_next = r_rr_ptr;
        if (w_gnt) begin
            w_rr_ptr_next = (w_pick == c_last) ? '0 : w_pick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ECRS; i++) begin
                r_state[i] <= ST_FREE;
            end
            r_owner      <= '0;
            r_busy       <= '0;
            r_rr_ptr     <= '0;
            r_free_count <= c_num;
            r_err        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ECRS; i++) begin
                r_state[i] <= w_state_next[i];
                r_busy[i]  <= (w_state_next[i] != ST_FREE);
            end
            if (w_gnt) begin
                r_owner[w_pick] <= alloc_issue_id;
            end
            r_rr_ptr     <= w_rr_ptr_next;
            r_free_count <= w_free_count_next;
            r_err        <= free_req & ~w_free_legal;
        end
    end

    assign busy_mask    = r_busy;
    assign owner_id     = r_owner;
    assign free_count   = r_free_count;
    assign err_bad_free = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ecr_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecr_allocator
// Purpose  : Table, directed and randomized checks of ecr_allocator against a
//            queue-free array reference model of the allocation lifecycle.
// Revision : 1.0
// ============================================================================
module tb_ecr_allocator;

    localparam int N = 8;

    logic             clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             alloc_req = 1'b0;
    logic [3:0]       alloc_issue_id = '0;
    logic             alloc_gnt;
    logic [2:0]       alloc_idx;
    logic             free_req = 1'b0;
    logic [2:0]       free_idx = '0;
    logic             flush = 1'b0;
    logic [7:0][1:0]  monitor_states = '0;
    logic [7:0]       busy_mask;
    logic [7:0][3:0]  owner_id;
    logic [3:0]       free_count;
    logic             err_bad_free;

    logic             rst6 = 1'b1;
    logic             free_req6 = 1'b0;
    logic [2:0]       free_idx6 = '0;
    logic             gnt6;
    logic [2:0]       idx6;
    logic [5:0]       busy6;
    logic [5:0][3:0]  owner6;
    logic [3:0]       fc6;
    logic             err6;

    ecr_allocator #(.NUM_ECRS(8), .ID_WIDTH(4), .IDLE_STATE(2'b00)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_issue_id(alloc_issue_id),
        .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .free_req(free_req),
        .free_idx(free_idx), .flush(flush), .monitor_states(monitor_states),
        .busy_mask(busy_mask), .owner_id(owner_id), .free_count(free_count),
        .err_bad_free(err_bad_free)
    );

    ecr_allocator #(.NUM_ECRS(6), .ID_WIDTH(4), .IDLE_STATE(2'b00)) dut6 (
        .clk(clk), .rst(rst6), .alloc_req(1'b0), .alloc_issue_id(4'h0),
        .alloc_gnt(gnt6), .alloc_idx(idx6), .free_req(free_req6),
        .free_idx(free_idx6), .flush(1'b0), .monitor_states(12'h000),
        .busy_mask(busy6), .owner_id(owner6), .free_count(fc6),
        .err_bad_free(err6)
    );

    // Reference model: 0=FREE, 1=ALLOC, 2=DRAIN
    int         m_state [N];
    logic [3:0] m_owner [N];
    int         m_rr;
    bit         m_err;

    int         tests = 0;
    int         fails = 0;
    bit         cap_gnt;
    int         cap_idx;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_free_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_state[i] == 0) c++;
        return c;
    endfunction

    // One clock cycle: drive at posedge+1, check combinational outputs
    // mid-cycle, advance the model, check registered outputs at next posedge+1.
    task automatic step(input bit r, input bit req, input logic [3:0] id,
                        input bit fr, input int fi, input bit fl,
                        input logic [15:0] mon);
        bit          eg;
        int          ei;
        int          ns [N];
        logic [7:0]  eb;
        logic [31:0] eo;
        rst            = r;
        alloc_req      = req;
        alloc_issue_id = id;
        free_req       = fr;
        free_idx       = 3'(fi);
        flush          = fl;
        monitor_states = mon;
        #3;
        eg = !r && req && !fl && (m_free_cnt() > 0);
        ei = 0;
        if (eg) begin
            for (int k = 0; k < N; k++) begin
                if (m_state[(m_rr + k) % N] == 0) begin
                    ei = (m_rr + k) % N;
                    break;
                end
            end
        end
        cap_gnt = alloc_gnt;
        cap_idx = int'(alloc_idx);
        chk("alloc_gnt", alloc_gnt, eg);
        chk("alloc_idx", alloc_idx, ei);
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] = 0;
                m_owner[i] = '0;
            end
            m_rr  = 0;
            m_err = 0;
        end else begin
            m_err = fr && !(fi < N && m_state[fi % N] == 1);
            for (int i = 0; i < N; i++) begin
                ns[i] = m_state[i];
                if (m_state[i] == 2 && mon[2*i +: 2] == 2'b00) ns[i] = 0;
                if (m_state[i] == 1 && (fl || (fr && fi == i))) ns[i] = 2;
            end
            if (eg) begin
                ns[ei]      = 1;
                m_owner[ei] = id;
                m_rr        = (ei + 1) % N;
            end
            for (int i = 0; i < N; i++) m_state[i] = ns[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            eb[i]        = (m_state[i] != 0);
            eo[4*i +: 4] = m_owner[i];
        end
        chk("busy_mask", busy_mask, eb);
        chk("free_count", free_count, m_free_cnt());
        chk("owner_id", owner_id, eo);
        chk("err_bad_free", err_bad_free, m_err);
    endtask

    task automatic idle(input logic [15:0] mon);
        step(0, 0, 4'h0, 0, 0, 0, mon);
    endtask

    typedef struct {
        bit          r;
        bit          req;
        logic [3:0]  id;
        bit          fr;
        int          fi;
        bit          fl;
        logic [15:0] mon;
        bit          eg;
        int          ei;
        int          efc;
        logic [7:0]  eb;
        bit          ee;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Fill, drain of entry 3, re-grant, illegal DRAIN free, flush.
        tbl.push_back('{1, 0, 4'd0, 0, 0, 0, 16'h0000, 0, 0, 8, 8'h00, 0});
        for (int k = 0; k < 8; k++)
            tbl.push_back('{0, 1, 4'(k + 1), 0, 0, 0, 16'h0000, 1, k, 7 - k,
                            8'((16'h1 << (k + 1)) - 1), 0});
        tbl.push_back('{0, 1, 4'd9,  0, 0, 0, 16'h0000, 0, 0, 0, 8'hFF, 0});
        tbl.push_back('{0, 0, 4'd0,  1, 3, 0, 16'h0040, 0, 0, 0, 8'hFF, 0});
        tbl.push_back('{0, 0, 4'd0,  0, 0, 0, 16'h0040, 0, 0, 0, 8'hFF, 0});
        tbl.push_back('{0, 0, 4'd0,  0, 0, 0, 16'h0000, 0, 0, 1, 8'hF7, 0});
        tbl.push_back('{0, 1, 4'd10, 0, 0, 0, 16'h0000, 1, 3, 0, 8'hFF, 0});
        tbl.push_back('{0, 0, 4'd0,  1, 3, 0, 16'h0040, 0, 0, 0, 8'hFF, 0});
        tbl.push_back('{0, 0, 4'd0,  1, 3, 0, 16'h0040, 0, 0, 0, 8'hFF, 1});
        tbl.push_back('{0, 0, 4'd0,  0, 0, 0, 16'h0040, 0, 0, 0, 8'hFF, 0});
        tbl.push_back('{0, 1, 4'd11, 0, 0, 1, 16'h5555, 0, 0, 0, 8'hFF, 0});
        tbl.push_back('{0, 0, 4'd0,  0, 0, 0, 16'h0000, 0, 0, 8, 8'h00, 0});
        tbl.push_back('{0, 1, 4'd12, 0, 0, 0, 16'h0000, 1, 4, 7, 8'h10, 0});

        for (int i = 0; i < N; i++) begin
            m_state[i] = 0;
            m_owner[i] = '0;
        end
        m_rr  = 0;
        m_err = 0;
        @(posedge clk);
        #1;

        foreach (tbl[v]) begin
            step(tbl[v].r, tbl[v].req, tbl[v].id, tbl[v].fr, tbl[v].fi, tbl[v].fl, tbl[v].mon);
            chk("tbl_gnt", cap_gnt, tbl[v].eg);
            chk("tbl_idx", cap_idx, tbl[v].ei);
            chk("tbl_free_count", free_count, tbl[v].efc);
            chk("tbl_busy_mask", busy_mask, tbl[v].eb);
            chk("tbl_err", err_bad_free, tbl[v].ee);
        end

        // Free of a FREE entry: one-cycle error pulse, nothing else changes.
        step(1, 0, 4'h0, 0, 0, 0, 16'h0000);
        step(0, 0, 4'h0, 1, 5, 0, 16'h0000);
        chk("free_free_err", err_bad_free, 1);
        chk("free_free_count", free_count, 8);
        idle(16'h0000);
        chk("free_free_err_drop", err_bad_free, 0);

        // Round-robin: freed idx 0 is skipped in favour of idx 1.
        step(1, 0, 4'h0, 0, 0, 0, 16'h0000);
        step(0, 1, 4'h2, 0, 0, 0, 16'h0000);
        chk("rr_first", cap_idx, 0);
        step(0, 0, 4'h0, 1, 0, 0, 16'h0000);
        idle(16'h0000);
        chk("rr_drained", free_count, 8);
        step(0, 1, 4'h3, 0, 0, 0, 16'h0000);
        chk("rr_next", cap_idx, 1);

        // Flush with alloc_req, entries 0-2 allocated, monitors busy.
        step(1, 0, 4'h0, 0, 0, 0, 16'h0000);
        for (int k = 0; k < 3; k++) step(0, 1, 4'(k + 4), 0, 0, 0, 16'h5555);
        step(0, 1, 4'h7, 0, 0, 1, 16'h5555);
        chk("flush_gnt", cap_gnt, 0);
        chk("flush_busy", busy_mask, 8'h07);
        idle(16'h0000);
        chk("flush_free_count", free_count, 8);
        step(0, 1, 4'h8, 0, 0, 0, 16'h0000);
        chk("flush_rr_kept", cap_idx, 3);

        // Reset with 4 ALLOC and 2 DRAIN entries.
        step(1, 0, 4'h0, 0, 0, 0, 16'h0000);
        for (int k = 0; k < 6; k++) step(0, 1, 4'(k + 1), 0, 0, 0, 16'h5555);
        step(0, 0, 4'h0, 1, 4, 0, 16'h5555);
        step(0, 0, 4'h0, 1, 5, 0, 16'h5555);
        step(1, 1, 4'hA, 1, 0, 1, 16'h5555);
        chk("midrst_busy", busy_mask, 8'h00);
        chk("midrst_free_count", free_count, 8);
        step(0, 1, 4'hB, 0, 0, 0, 16'h5555);
        chk("midrst_first_idx", cap_idx, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 60,
                 4'($urandom),
                 $urandom_range(0, 99) < 40,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 4,
                 16'($urandom & $urandom));
        end

        // Six-entry build: index 7 is out of range.
        rst6 = 1'b1;
        @(posedge clk);
        #1;
        rst6 = 1'b0;
        chk("n6_free_count", fc6, 6);
        free_req6 = 1'b1;
        free_idx6 = 3'd7;
        @(posedge clk);
        #1;
        free_req6 = 1'b0;
        chk("n6_oor_err", err6, 1);
        chk("n6_oor_busy", busy6, 6'h00);
        @(posedge clk);
        #1;
        chk("n6_oor_err_drop", err6, 0);
        chk("n6_free_count_kept", fc6, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
